// File: rtl/mem8_target.sv
// Bus-to-8-bit asynchronous memory bridge: splits a 16-bit request into one or
// two byte accesses with SETUP / STROBE / HOLD phases, then pulses compl.
module mem8_target #(
   parameter int AW   = 20,
   parameter int WAIT = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   addr,
   input  logic [15:0]   wdata,
   input  logic          wr_en,
   input  logic [1:0]    bytesel,
   output logic [15:0]   rdata,
   output logic          compl,
   output logic [AW-1:0] m_addr,
   output logic [7:0]    m_dout,
   input  logic [7:0]    m_din,
   output logic          m_doe,
   output logic          m_ce_n,
   output logic          m_oe_n,
   output logic          m_we_n
);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, COMPL} state_t;

   localparam logic [3:0] WAIT_M1 = 4'(WAIT - 1);

   state_t         state, state_nxt;
   logic           byte_q, byte_nxt;
   logic [3:0]     cnt, cnt_nxt;
   logic [AW-1:1]  addr_q;
   logic [15:0]    wdata_q;
   logic           wr_q;
   logic [1:0]     sel_q;

   logic           accept;
   logic [AW-1:1]  src_addr;
   logic [15:0]    src_wdata;
   logic           src_wr;
   logic           active_nxt;
   logic           ce_n_nxt, oe_n_nxt, we_n_nxt, doe_nxt;
   logic [AW-1:0]  m_addr_nxt;
   logic [7:0]     m_dout_nxt;
   logic           last_strobe;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:AW], addr[0]};

   assign accept      = (state == IDLE) && (bytesel != 2'b00);
   assign last_strobe = (state == STROBE) && (cnt == 4'd0);

   // Pin values for the first access come straight from the bus at accept;
   // later accesses use the latched copy.
   always_comb begin
      src_addr  = accept ? addr[AW-1:1] : addr_q;
      src_wdata = accept ? wdata        : wdata_q;
      src_wr    = accept ? wr_en        : wr_q;
   end

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      byte_nxt  = byte_q;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SETUP;
               byte_nxt  = ~bytesel[0];
            end
         end
         SETUP: begin
            state_nxt = STROBE;
            cnt_nxt   = WAIT_M1;
         end
         STROBE: begin
            if (cnt == 4'd0) state_nxt = HOLD;
            else             cnt_nxt   = cnt - 4'd1;
         end
         HOLD: begin
            if (!byte_q && sel_q == 2'b11) begin
               state_nxt = SETUP;
               byte_nxt  = 1'b1;
            end else begin
               state_nxt = COMPL;
            end
         end
         COMPL:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Pins are registered, so they are derived from the state being entered.
   always_comb begin
      active_nxt = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
      ce_n_nxt   = ~active_nxt;
      oe_n_nxt   = ~((state_nxt == STROBE) && !src_wr);
      we_n_nxt   = ~((state_nxt == STROBE) &&  src_wr);
      doe_nxt    = active_nxt && src_wr;
      m_addr_nxt = m_addr;
      m_dout_nxt = m_dout;
      if (state_nxt == SETUP) begin
         m_addr_nxt = {src_addr, byte_nxt};
         m_dout_nxt = byte_nxt ? src_wdata[15:8] : src_wdata[7:0];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         byte_q  <= 1'b0;
         cnt     <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 16'd0;
         wr_q    <= 1'b0;
         sel_q   <= 2'b00;
      end else begin
         state  <= state_nxt;
         byte_q <= byte_nxt;
         cnt    <= cnt_nxt;
         if (accept) begin
            addr_q  <= addr[AW-1:1];
            wdata_q <= wdata;
            wr_q    <= wr_en;
            sel_q   <= bytesel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata  <= 16'd0;
         compl  <= 1'b0;
         m_addr <= '0;
         m_dout <= 8'd0;
         m_doe  <= 1'b0;
         m_ce_n <= 1'b1;
         m_oe_n <= 1'b1;
         m_we_n <= 1'b1;
      end else begin
         compl  <= (state_nxt == COMPL);
         m_addr <= m_addr_nxt;
         m_dout <= m_dout_nxt;
         m_doe  <= doe_nxt;
         m_ce_n <= ce_n_nxt;
         m_oe_n <= oe_n_nxt;
         m_we_n <= we_n_nxt;
         if (accept) begin
            rdata <= 16'd0;
         end else if (last_strobe && !wr_q) begin
            if (byte_q) rdata[15:8] <= m_din;
            else        rdata[7:0]  <= m_din;
         end
      end
   end

endmodule

// File: tb/tb_mem8_target.sv
// Directed bench for mem8_target: a byte-wide memory model answers both a
// WAIT=3 and a WAIT=1 instance; cycle 0 is the cycle a request is presented.
module tb_mem8_target;

   localparam int AW = 20;
   localparam int W  = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   addr = '0;
   logic [15:0]   wdata = '0;
   logic          wr_en = 1'b0;
   logic [1:0]    bytesel = 2'b00;
   logic [15:0]   rdata;
   logic          compl;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_dout, m_din;
   logic          m_doe, m_ce_n, m_oe_n, m_we_n;

   logic [31:0]   w1_addr = '0;
   logic [15:0]   w1_wdata = '0;
   logic          w1_wr_en = 1'b0;
   logic [1:0]    w1_bytesel = 2'b00;
   logic [15:0]   w1_rdata;
   logic          w1_compl;
   logic [AW-1:0] w1_m_addr;
   logic [7:0]    w1_m_dout, w1_m_din;
   logic          w1_m_doe, w1_m_ce_n, w1_m_oe_n, w1_m_we_n;

   logic [7:0] mem [0:1023];

   int n_chk = 0, n_pass = 0, viol = 0;
   int c_cyc, n_strobe, w1_c, cnt_compl;
   logic [AW-1:0] a_first, a_last;
   logic [7:0]    d_last;
   logic [15:0]   r_setup, r_compl;
   bit            seen;

   always #5 clk = ~clk;

   assign m_din    = mem[m_addr[9:0]];
   assign w1_m_din = mem[w1_m_addr[9:0]];

   mem8_target #(.AW(AW), .WAIT(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wr_en(wr_en),
      .bytesel(bytesel), .rdata(rdata), .compl(compl), .m_addr(m_addr),
      .m_dout(m_dout), .m_din(m_din), .m_doe(m_doe), .m_ce_n(m_ce_n),
      .m_oe_n(m_oe_n), .m_we_n(m_we_n)
   );

   mem8_target #(.AW(AW), .WAIT(1)) u_dut_w1 (
      .clk(clk), .rst_n(rst_n), .addr(w1_addr), .wdata(w1_wdata), .wr_en(w1_wr_en),
      .bytesel(w1_bytesel), .rdata(w1_rdata), .compl(w1_compl), .m_addr(w1_m_addr),
      .m_dout(w1_m_dout), .m_din(w1_m_din), .m_doe(w1_m_doe), .m_ce_n(w1_m_ce_n),
      .m_oe_n(w1_m_oe_n), .m_we_n(w1_m_we_n)
   );

   // Strobe exclusivity and no drive during reads, on every cycle of both instances.
   always @(negedge clk) begin
      if (!m_oe_n && !m_we_n)       viol++;
      if (m_doe && !m_oe_n)         viol++;
      if (!w1_m_oe_n && !w1_m_we_n) viol++;
      if (w1_m_doe && !w1_m_oe_n)   viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Presents one request (now=1: in the current cycle, else at the next
   // negedge), scrambles the bus once the access starts, and samples every
   // cycle until compl or a 60-cycle budget. Writes land in the memory model.
   task automatic xfer(input bit now, input logic [31:0] a, input logic [15:0] wd,
                       input logic w, input logic [1:0] bs);
      bit cleared;
      if (!now) @(negedge clk);
      addr = a; wdata = wd; wr_en = w; bytesel = bs;
      c_cyc = -1; n_strobe = 0; cleared = 0;
      r_setup = 16'hDEAD; r_compl = 16'hDEAD; a_first = '1; a_last = '1; d_last = 8'h00;
      for (int cyc = 1; cyc <= 60 && c_cyc < 0; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (!m_ce_n && !cleared) begin
            cleared = 1; r_setup = rdata;
            bytesel = 2'b00; addr = '1; wdata = '1; wr_en = ~w;
         end
         if (!m_oe_n || !m_we_n) begin
            if (n_strobe == 0) a_first = m_addr;
            a_last = m_addr; d_last = m_dout; n_strobe++;
            if (!m_we_n) mem[m_addr[9:0]] = m_dout;
         end
         if (compl) begin c_cyc = cyc; r_compl = rdata; end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[10'h100] = 8'h34; mem[10'h101] = 8'h12; mem[10'h200] = 8'h11;
      mem[10'h010] = 8'h5A; mem[10'h011] = 8'h5A;

      // Reset values, with a read request already held on the bus.
      addr = 32'h100; bytesel = 2'b01; wr_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctl", {compl, m_ce_n, m_oe_n, m_we_n, m_doe}, 5'b01110);
      check("rst_rdata", rdata, 16'h0000);
      check("rst_maddr", m_addr, 0);
      check("rst_mdout", m_dout, 0);
      rst_n = 1'b1;
      xfer(1, 32'h100, 16'h0, 1'b0, 2'b01);
      check("held_req_compl_cyc", c_cyc, W + 3);
      check("held_req_rdata", r_compl, 16'h0034);

      // 16-bit read, byte 0 then byte 1.
      xfer(0, 32'h100, 16'h0, 1'b0, 2'b11);
      check("rd16_compl_cyc", c_cyc, 2 * W + 5);
      check("rd16_strobes", n_strobe, 2 * W);
      check("rd16_addr0", a_first, 32'h100);
      check("rd16_addr1", a_last, 32'h101);
      check("rd16_clear_at_accept", r_setup, 16'h0000);
      check("rd16_rdata", r_compl, 16'h1234);

      // Byte-1 write.
      xfer(0, 32'h200, 16'hAB00, 1'b1, 2'b10);
      check("wr_hi_compl_cyc", c_cyc, W + 3);
      check("wr_hi_strobes", n_strobe, W);
      check("wr_hi_addr", a_first, 32'h201);
      check("wr_hi_addr_last", a_last, 32'h201);
      check("wr_hi_dout", d_last, 8'hAB);
      check("wr_hi_rdata", r_compl, 16'h0000);
      check("wr_hi_mem_lo_kept", mem[10'h200], 8'h11);

      // Byte-0 write, then read both bytes back.
      xfer(0, 32'h300, 16'h12C3, 1'b1, 2'b01);
      check("wr_lo_addr", a_first, 32'h300);
      check("wr_lo_dout", d_last, 8'hC3);
      xfer(0, 32'h200, 16'h0, 1'b0, 2'b11);
      check("rdback_rdata", r_compl, 16'hAB11);
      xfer(0, 32'h300, 16'h0, 1'b0, 2'b01);
      check("rdback_lo_rdata", r_compl, 16'h00C3);

      // Back-to-back: second request presented in the compl cycle; addr bit 0 ignored.
      xfer(0, 32'h100, 16'h0, 1'b0, 2'b01);
      check("b2b_first_rdata", r_compl, 16'h0034);
      xfer(1, 32'h201, 16'h0, 1'b0, 2'b01);
      check("b2b_second_compl_cyc", c_cyc, W + 4);
      check("b2b_second_addr", a_first, 32'h200);
      check("b2b_second_rdata", r_compl, 16'h0011);

      // rdata stability across idle cycles, cleared at the next accept.
      xfer(0, 32'h010, 16'h0, 1'b0, 2'b11);
      check("stab_rdata", r_compl, 16'h5A5A);
      repeat (5) @(negedge clk);
      check("stab_rdata_idle", rdata, 16'h5A5A);
      xfer(0, 32'h100, 16'h0, 1'b0, 2'b10);
      check("stab_clear_at_accept", r_setup, 16'h0000);
      check("stab_next_rdata", r_compl, 16'h1200);

      // Reset during STROBE.
      @(negedge clk);
      addr = 32'h100; bytesel = 2'b11; wr_en = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!m_ce_n) bytesel = 2'b00;
         if (!m_oe_n) seen = 1;
      end
      check("rstmid_strobe_seen", 32'(seen), 1);
      rst_n = 1'b0;
      #1;
      check("rstmid_strobes", {m_ce_n, m_oe_n, m_we_n, m_doe}, 4'b1110);
      check("rstmid_maddr", m_addr, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt_compl = 0;
      repeat (20) begin
         @(posedge clk);
         @(negedge clk);
         if (compl) cnt_compl++;
      end
      check("rstmid_no_compl", cnt_compl, 0);
      xfer(0, 32'h101, 16'h0, 1'b0, 2'b01);
      check("rstmid_next_compl_cyc", c_cyc, W + 3);
      check("rstmid_next_rdata", r_compl, 16'h0034);

      // WAIT=1 instance, bytesel dropped right after accept.
      @(negedge clk);
      w1_addr = 32'h100; w1_bytesel = 2'b01; w1_wr_en = 1'b0;
      w1_c = -1;
      for (int cyc = 1; cyc <= 20 && w1_c < 0; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (cyc == 1) w1_bytesel = 2'b00;
         if (w1_compl) w1_c = cyc;
      end
      check("w1_compl_cyc", w1_c, 4);
      check("w1_rdata", w1_rdata, 16'h0034);
      @(negedge clk);
      check("w1_compl_one_cycle", 32'(w1_compl), 0);

      check("strobe_overlap_or_read_drive", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
